// File: rtl/fetch_stage_pkg.sv
// Shared constants and IF/ID bundle type for the fetch stage.
// Halt detection is compiled in with FETCH_HALT_EN.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [ILEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// Instruction memory: one synchronous write port, one combinational read.
// Contents are never reset.
module instr_mem
    import fetch_stage_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [ILEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [ILEN-1:0] rdata
);

    logic [ILEN-1:0] mem [IMEM_DEPTH];

    // Loader write commits at the edge; a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction memory, IF/ID register.
// FETCH_HALT_EN compiles in sticky halt on the all-ones word.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        ClockIn,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        MemWriteEn,
    input  logic [31:0] MemWriteAddr,
    input  logic [31:0] MemWriteData,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid,
    output logic        Halted
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic            halted_q, halted_d;

    logic [ILEN-1:0] fetch_word;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_next;
    logic            halt_hit;
    logic            unused_bits;

    instr_mem #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .AW        (AW)
    ) u_imem (
        .clk  (ClockIn),
        .we   (MemWriteEn),
        .waddr(MemWriteAddr[AW+1:2]),
        .wdata(MemWriteData),
        .raddr(pc_q[AW+1:2]),
        .rdata(fetch_word)
    );

    assign unused_bits = ^{MemWriteAddr[31:AW+2],
                           MemWriteAddr[1:0],
                           PCTarget[1:0]};

    assign pc_seq  = pc_q + PC_STEP;
    assign pc_next = PCSrc ? {PCTarget[31:2], 2'b00} : pc_seq;

`ifdef FETCH_HALT_EN
    assign halt_hit = (fetch_word == HALT_INSTR);
`else
    assign halt_hit = 1'b0;
`endif

    // Next PC / IF/ID / halt: Reset > Flush > Stall > halt > fetch.
    always_comb begin
        pc_d     = pc_q;
        if_id_d  = if_id_q;
        halted_d = halted_q;
        if (Reset) begin
            pc_d     = RESET_PC;
            if_id_d  = '0;
            halted_d = 1'b0;
        end else if (Flush) begin
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
            if (!halted_q) begin
                pc_d = pc_next;
            end
        end else if (Stall || halted_q) begin
            pc_d = pc_q;
        end else if (halt_hit) begin
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
            halted_d      = 1'b1;
        end else begin
            pc_d             = pc_next;
            if_id_d.instr    = fetch_word;
            if_id_d.pc_plus4 = pc_seq;
            if_id_d.valid    = 1'b1;
        end
    end

    // State registers; Reset is folded into the _d logic above.
    always_ff @(posedge ClockIn) begin
        pc_q     <= pc_d;
        if_id_q  <= if_id_d;
        halted_q <= halted_d;
    end

    assign Instruction = if_id_q.instr;
    assign PCPlus4     = if_id_q.pc_plus4;
    assign Valid       = if_id_q.valid;
    assign Halted      = halted_q;

endmodule
